slt_pipe_unit: RTL and testbench

//  Set-less-than execution unit for the CPU datapath: implements SLT, SLTU, SLTI and SLTIU.
//  It is parametrised in operand/immediate width and carries a tag through a 2-stage pipeline.
//  A valid/ready handshake on both sides lets it sit between decode/issue and writeback.

---
 rtl/slt_pipe_unit.sv | 109 ++++++++++
 tb/tb_slt_pipe_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/slt_pipe_unit.sv
// Two-stage SLT/SLTU/SLTI/SLTIU unit with valid/ready on both sides and tag pass-through.
// Optional true-result counter is compiled in with `define SLT_STATS_EN.
module slt_pipe_unit #(
    parameter int WIDTH     = 16,
    parameter int IMM_WIDTH = 16,
    parameter int TAG_WIDTH = 5,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     rs,
    input  logic [WIDTH-1:0]     rt,
    input  logic [IMM_WIDTH-1:0] imm,
    input  logic [TAG_WIDTH-1:0] tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic [TAG_WIDTH-1:0] tag_out
`ifdef SLT_STATS_EN
    ,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] true_count
`endif
);

    if (WIDTH < 2 || IMM_WIDTH < 1 || IMM_WIDTH > WIDTH || TAG_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_params
        $error("slt_pipe_unit: illegal parameter combination");
    end

    function automatic logic signed [WIDTH-1:0] sign_ext(input logic [IMM_WIDTH-1:0] v);
        return WIDTH'($signed(v));
    endfunction

    function automatic logic less_than(input logic signed [WIDTH-1:0] a,
                                       input logic signed [WIDTH-1:0] b,
                                       input logic sgn);
        return sgn ? (a < b) : ($unsigned(a) < $unsigned(b));
    endfunction

    logic                    vld_p1;
    logic signed [WIDTH-1:0] a_p1;
    logic signed [WIDTH-1:0] b_p1;
    logic                    signed_p1;
    logic [TAG_WIDTH-1:0]    tag_p1;
    logic                    lt_p2;
    logic                    s2_free;
    logic                    s1_advance;
    logic                    accept;

    assign s2_free    = !out_valid || out_ready;
    assign s1_advance = vld_p1 && s2_free;
    assign in_ready   = !vld_p1 || s1_advance;
    assign accept     = in_valid && in_ready;

    // Stage 1: capture operands; B is chosen and sign-extended here so stage 2 only compares
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1      <= $signed(rs);
            b_p1      <= op[1] ? sign_ext(imm) : $signed(rt);
            signed_p1 <= ~op[0];
            tag_p1    <= tag_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (s1_advance) begin
            vld_p1 <= 1'b0;
        end
    end

    // Stage 2: compare; holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            lt_p2     <= 1'b0;
            tag_out   <= '0;
        end else begin
            if (s2_free) begin
                out_valid <= vld_p1;
            end
            if (s1_advance) begin
                lt_p2   <= less_than(a_p1, b_p1, signed_p1);
                tag_out <= tag_p1;
            end
        end
    end

    assign result = {{(WIDTH-1){1'b0}}, lt_p2};

`ifdef SLT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            true_count <= '0;
        end else if (cnt_clr) begin
            true_count <= '0;
        end else if (out_valid && out_ready && lt_p2 && !(&true_count)) begin
            true_count <= true_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_slt_pipe_unit.sv
// Bench for slt_pipe_unit: 16-bit-immediate instance plus an 8-bit-immediate, 2-bit-counter
// instance running in lockstep; a queue model checks every output, directed tests pin values.
module tb_slt_pipe_unit;

    localparam logic [1:0] SLT = 2'b00, SLTU = 2'b01, SLTI = 2'b10, SLTIU = 2'b11;

    logic        clk, rst_n, in_valid, out_ready, cnt_clr;
    logic [1:0]  op;
    logic [15:0] rs, rt, imm;
    logic [4:0]  tag_in;
    logic        in_ready, out_valid, in_ready8, out_valid8;
    logic [15:0] result, result8;
    logic [4:0]  tag_out, tag_out8;
`ifdef SLT_STATS_EN
    logic [15:0] true_count;
    logic [1:0]  true_count8;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] res;
        logic [4:0]  tag;
    } exp_t;
    exp_t q16[$];
    exp_t q8[$];
    longint cnt16, cnt8;

    slt_pipe_unit #(.WIDTH(16), .IMM_WIDTH(16), .TAG_WIDTH(5), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .rs(rs), .rt(rt), .imm(imm), .tag_in(tag_in), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .tag_out(tag_out)
`ifdef SLT_STATS_EN
        , .cnt_clr(cnt_clr), .true_count(true_count)
`endif
    );

    slt_pipe_unit #(.WIDTH(16), .IMM_WIDTH(8), .TAG_WIDTH(5), .CNT_WIDTH(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8), .op(op),
        .rs(rs), .rt(rt), .imm(imm[7:0]), .tag_in(tag_in), .out_valid(out_valid8),
        .out_ready(out_ready), .result(result8), .tag_out(tag_out8)
`ifdef SLT_STATS_EN
        , .cnt_clr(cnt_clr), .true_count(true_count8)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: interpret operands as mathematical integers, B from imm sign-extended from iw bits
    function automatic logic model_lt(input logic [1:0] o, input logic [15:0] a,
                                      input logic [15:0] b, input logic [15:0] im, input int iw);
        longint au, as_, bs, bu, imv, span;
        au  = longint'(a);
        as_ = a[15] ? au - 65536 : au;
        if (o[1]) begin
            span = longint'(1) << iw;
            imv  = longint'(im) & (span - 1);
            bs   = (imv >= span / 2) ? imv - span : imv;
        end else begin
            bs = b[15] ? longint'(b) - 65536 : longint'(b);
        end
        bu = (bs < 0) ? bs + 65536 : bs;
        return o[0] ? (au < bu) : (as_ < bs);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q16.delete(); q8.delete();
            cnt16 = 0; cnt8 = 0;
        end else begin
            if (out_valid) begin
                if (q16.size() == 0) chk("mon16_unexpected_out", 32'(out_valid), 32'd0);
                else begin
                    chk("mon16_result", 32'(result), 32'(q16[0].res));
                    chk("mon16_tag", 32'(tag_out), 32'(q16[0].tag));
                end
            end
            if (out_valid8) begin
                if (q8.size() == 0) chk("mon8_unexpected_out", 32'(out_valid8), 32'd0);
                else begin
                    chk("mon8_result", 32'(result8), 32'(q8[0].res));
                    chk("mon8_tag", 32'(tag_out8), 32'(q8[0].tag));
                end
            end
`ifdef SLT_STATS_EN
            chk("mon16_true_count", 32'(true_count), 32'(cnt16));
            chk("mon8_true_count", 32'(true_count8), 32'(cnt8));
`endif
            if (cnt_clr) begin
                cnt16 = 0; cnt8 = 0;
            end else begin
                if (out_valid && out_ready && q16.size() > 0 && q16[0].res[0] && cnt16 < 65535) cnt16++;
                if (out_valid8 && out_ready && q8.size() > 0 && q8[0].res[0] && cnt8 < 3) cnt8++;
            end
            if (out_valid && out_ready && q16.size() > 0) void'(q16.pop_front());
            if (out_valid8 && out_ready && q8.size() > 0) void'(q8.pop_front());
            if (in_valid && in_ready)
                q16.push_back('{res: 16'(model_lt(op, rs, rt, imm, 16)), tag: tag_in});
            if (in_valid && in_ready8)
                q8.push_back('{res: 16'(model_lt(op, rs, rt, imm, 8)), tag: tag_in});
        end
    end

    task automatic set_req(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] im, input logic [4:0] t);
        in_valid = 1'b1; op = o; rs = a; rt = b; imm = im; tag_in = t;
    endtask

    task automatic single(input string name, input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] im, input logic [4:0] t,
                          input logic [15:0] exp16, input logic [15:0] exp8);
        set_req(o, a, b, im, t);
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({name, "_not_yet_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({name, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_result"}, 32'(result), 32'(exp16));
        chk({name, "_result8"}, 32'(result8), 32'(exp8));
        chk({name, "_tag"}, 32'(tag_out), 32'(t));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic stream(input logic [15:0] a[], input logic [15:0] b[]);
        for (int i = 0; i < a.size(); i++) begin
            set_req(SLT, a[i], b[i], 16'h0, 5'(i));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int naccept;
        logic acc;
        logic [4:0] tg;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        op = SLT; rs = '0; rt = '0; imm = '0; tag_in = '0;
        #12;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_tag_out", 32'(tag_out), 32'd0);
`ifdef SLT_STATS_EN
        chk("reset_true_count", 32'(true_count), 32'd0);
`endif
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        single("slt_neg_vs_pos", SLT, 16'hFFFF, 16'h0001, 16'h0, 5'd3, 16'h1, 16'h1);
        single("sltu_same_ops", SLTU, 16'hFFFF, 16'h0001, 16'h0, 5'd4, 16'h0, 16'h0);
        single("slti_equal", SLTI, 16'h0005, 16'h0, 16'h0005, 5'd5, 16'h0, 16'h0);
        single("sltiu_sext", SLTIU, 16'h8000, 16'h0, 16'hFFFF, 5'd6, 16'h1, 16'h1);
        single("slti_imm8_neg", SLTI, 16'hFFF0, 16'h0, 16'h0080, 5'd7, 16'h1, 16'h0);
        single("slt_minneg_maxpos", SLT, 16'h8000, 16'h7FFF, 16'h0, 5'd8, 16'h1, 16'h1);
        single("sltu_minneg_maxpos", SLTU, 16'h8000, 16'h7FFF, 16'h0, 5'd9, 16'h0, 16'h0);

        // Back-to-back stream: tag i accepted on edge i+1, visible after edge i+2
        set_req(SLT, 16'd0, 16'd4, 16'h0, 5'd0);
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            if (i < 8) set_req(SLT, 16'(i), 16'd4, 16'h0, 5'(i));
            else in_valid = 1'b0;
            if (i >= 2) begin
                chk("stream_out_valid", 32'(out_valid), 32'd1);
                chk("stream_tag", 32'(tag_out), 32'(i - 2));
                chk("stream_result", 32'(result), 32'((i - 2) < 4));
            end
        end
        @(posedge clk); #1;
        chk("stream_drained", 32'(out_valid), 32'd0);

        // Consumer stall with a continuously valid producer
        out_ready = 1'b0;
        tg = 5'd10;
        naccept = 0;
        set_req(SLT, 16'd0, 16'd1, 16'h0, tg);
        for (int c = 0; c < 5; c++) begin
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                naccept++;
                tg = tg + 5'd1;
                set_req(SLT, 16'd5, 16'd1, 16'h0, tg);
            end
        end
        chk("stall_accepts", 32'(naccept), 32'd2);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_tag_held", 32'(tag_out), 32'd10);
        chk("stall_result_held", 32'(result), 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain_second_valid", 32'(out_valid), 32'd1);
        chk("drain_second_tag", 32'(tag_out), 32'd11);
        chk("drain_second_result", 32'(result), 32'd0);
        @(posedge clk); #1;
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset with both stages occupied
        out_ready = 1'b0;
        set_req(SLT, 16'd1, 16'd2, 16'h0, 5'd21);
        @(posedge clk); #1;
        set_req(SLT, 16'd1, 16'd2, 16'h0, 5'd22);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("prereset_full_valid", 32'(out_valid), 32'd1);
        chk("prereset_full_result", 32'(result), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_result", 32'(result), 32'd0);
        chk("midreset_tag", 32'(tag_out), 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("postreset_empty", 32'(out_valid), 32'd0);
        single("postreset_req", SLTU, 16'h0001, 16'hFFFF, 16'h0, 5'd23, 16'h1, 16'h1);

`ifdef SLT_STATS_EN
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("stats_cleared", 32'(true_count), 32'd0);
        stream('{16'd1, 16'd3, 16'hFFFF, 16'd5, 16'd0}, '{16'd2, 16'd2, 16'd0, 16'd5, 16'd7});
        chk("stats_3_true", 32'(true_count), 32'd3);
        chk("stats8_3_true", 32'(true_count8), 32'd3);
        stream('{16'd1, 16'd1}, '{16'd2, 16'd2});
        chk("stats_5_true", 32'(true_count), 32'd5);
        chk("stats8_saturated", 32'(true_count8), 32'd3);
        set_req(SLT, 16'd1, 16'd2, 16'h0, 5'd30);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("clr_race_out_valid", 32'(out_valid), 32'd1);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("clr_wins", 32'(true_count), 32'd0);
        chk("clr_wins8", 32'(true_count8), 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue16_empty", 32'(q16.size()), 32'd0);
        chk("final_queue8_empty", 32'(q8.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
